// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Optional stall counter is built only when PIPE_PERF_CNT_EN is defined.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } dmem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A register dependency only counts when the producer is not $zero.
    function automatic logic reg_dep(
        input logic [4:0] dst,
        input logic [4:0] src
    );
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stage controls out.
// stall_cnt_o and PERF_W exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if
`ifdef PIPE_PERF_CNT_EN
    #(parameter int PERF_W = 32)
`endif
    ;

    logic       IDEX_MemRead_i;
    logic [4:0] IDEX_rt_i;
    logic [4:0] IFID_rs_i;
    logic [4:0] IFID_rt_i;
    logic       branch_taken_i;
    logic       EXMEM_MemRead_i;
    logic       EXMEM_MemWrite_i;
    logic       dmem_ack_i;

    logic       dmem_req_o;
    logic       pc_write_o;
    logic       ifid_write_o;
    logic       ifid_flush_o;
    logic       idex_hold_o;
    logic       idex_bubble_o;
    logic       exmem_hold_o;
    logic       memwb_bubble_o;
    logic       mem_timeout_o;
`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_o;
`endif

    // Pipeline side: reports hazard sources, consumes stage controls.
    modport master (
        output IDEX_MemRead_i, IDEX_rt_i, IFID_rs_i, IFID_rt_i,
        output branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i,
        output dmem_ack_i,
        input  dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o,
        input  idex_hold_o, idex_bubble_o, exmem_hold_o,
        input  memwb_bubble_o, mem_timeout_o
`ifdef PIPE_PERF_CNT_EN
        , input stall_cnt_o
`endif
    );

    // Controller side.
    modport slave (
        input  IDEX_MemRead_i, IDEX_rt_i, IFID_rs_i, IFID_rt_i,
        input  branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i,
        input  dmem_ack_i,
        output dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o,
        output idex_hold_o, idex_bubble_o, exmem_hold_o,
        output memwb_bubble_o, mem_timeout_o
`ifdef PIPE_PERF_CNT_EN
        , output stall_cnt_o
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_dmem_wait_fsm.sv
// Data-memory req/ack sequencer with wait counter and sticky timeout.
// Independent of PIPE_PERF_CNT_EN.
module dmem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_op,
    input  logic ack,
    output logic dmem_req,
    output logic mem_stall,
    output logic mem_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    dmem_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tmo_q;

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            tmo_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tmo_q <= (state_nxt == ERR);
        end
    end

    // Next state: open a wait window on an unacked access, time out at the limit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (mem_op && !ack) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (ack) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: request and freeze, both forced quiet while reset is held.
    always_comb begin
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        if (!rst_i) begin
            unique case (state)
                IDLE: begin
                    dmem_req  = mem_op;
                    mem_stall = mem_op && !ack;
                end
                WAIT: begin
                    dmem_req  = 1'b1;
                    mem_stall = !ack;
                end
                ERR: begin
                    dmem_req  = 1'b0;
                    mem_stall = 1'b1;
                end
                default: begin
                    dmem_req  = 1'b0;
                    mem_stall = 1'b0;
                end
            endcase
        end
    end

    assign mem_timeout = tmo_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards, flush, memory freeze.
// Define PIPE_PERF_CNT_EN to add the saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_hazard_ctrl_if.slave bus
);

    logic mem_op;
    logic mem_stall;
    logic load_use;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_hold;
    logic idex_bubble;
    logic exmem_hold;
    logic memwb_bubble;

    assign mem_op = bus.EXMEM_MemRead_i | bus.EXMEM_MemWrite_i;

    dmem_wait_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mem_op      (mem_op),
        .ack         (bus.dmem_ack_i),
        .dmem_req    (bus.dmem_req_o),
        .mem_stall   (mem_stall),
        .mem_timeout (bus.mem_timeout_o)
    );

    assign load_use = bus.IDEX_MemRead_i
                    & (reg_dep(bus.IDEX_rt_i, bus.IFID_rs_i)
                    |  reg_dep(bus.IDEX_rt_i, bus.IFID_rt_i));

    // Priority: memory freeze, then load-use bubble, then branch flush.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        priority case (1'b1)
            rst_i: begin
                pc_write = 1'b1;
            end
            mem_stall: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end
            load_use: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            bus.branch_taken_i: begin
                ifid_flush = 1'b1;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.ifid_write_o   = ifid_write;
    assign bus.ifid_flush_o   = ifid_flush;
    assign bus.idex_hold_o    = idex_hold;
    assign bus.idex_bubble_o  = idex_bubble;
    assign bus.exmem_hold_o   = exmem_hold;
    assign bus.memwb_bubble_o = memwb_bubble;

`ifdef PIPE_PERF_CNT_EN
    // Count cycles in which the PC is frozen, sticking at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.stall_cnt_o <= '0;
        end else if (!pc_write && !(&bus.stall_cnt_o)) begin
            bus.stall_cnt_o <= bus.stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases plus random traffic.
// Checks stall_cnt_o as well when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
    pipe_hazard_ctrl_if #(.PERF_W(32)) bus();
`else
    pipe_hazard_ctrl_if bus();
`endif

    pipe_hazard_ctrl #(
        .TIMEOUT_CYC (TMO),
        .CNT_W       (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [8:0]  ctl;
        logic [31:0] scnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: access in flight, cycles waited, dead after timeout.
    bit     m_busy = 0;
    bit     m_dead = 0;
    int     m_waited = 0;
    longint m_scnt = 0;

    task automatic step(
        input string    tag,
        input bit       r,
        input bit       mr,
        input bit [4:0] xrt,
        input bit [4:0] rs,
        input bit [4:0] rt,
        input bit       br,
        input bit       rd,
        input bit       wr,
        input bit       ack
    );
        bit   mem_op, stall, req, lu;
        bit   pcw, ifw, fl, hold, bub, exh, mwb;
        exp_t e;
        @(posedge clk);
        #1;
        rst                  = r;
        bus.IDEX_MemRead_i   = mr;
        bus.IDEX_rt_i        = xrt;
        bus.IFID_rs_i        = rs;
        bus.IFID_rt_i        = rt;
        bus.branch_taken_i   = br;
        bus.EXMEM_MemRead_i  = rd;
        bus.EXMEM_MemWrite_i = wr;
        bus.dmem_ack_i       = ack;
        mem_op = rd || wr;
        lu = mr && (xrt != 0) && (xrt == rs || xrt == rt);
        if (m_dead) begin
            req = 0;
            stall = 1;
        end else if (m_busy) begin
            req = 1;
            stall = !ack;
        end else begin
            req = mem_op;
            stall = mem_op && !ack;
        end
        pcw = 1; ifw = 1; fl = 0; hold = 0; bub = 0; exh = 0; mwb = 0;
        if (r) begin
            req = 0;
        end else if (stall) begin
            pcw = 0; ifw = 0; hold = 1; exh = 1; mwb = 1;
        end else if (lu) begin
            pcw = 0; ifw = 0; bub = 1;
        end else if (br) begin
            fl = 1;
        end
        e.ctl  = {req, pcw, ifw, fl, hold, bub, exh, mwb, (!r && m_dead)};
        e.scnt = r ? 32'd0 : 32'(m_scnt);
        exp_q.push_back(e);
        name_q.push_back(tag);
        if (r) begin
            m_busy = 0;
            m_dead = 0;
            m_waited = 0;
            m_scnt = 0;
        end else begin
            if (!pcw && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (m_dead) begin
                m_dead = 1;
            end else if (m_busy) begin
                if (ack) begin
                    m_busy = 0;
                end else if (m_waited == TMO) begin
                    m_dead = 1;
                    m_busy = 0;
                end else begin
                    m_waited++;
                end
            end else if (mem_op && !ack) begin
                m_busy = 1;
                m_waited = 1;
            end
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    initial begin : monitor
        exp_t       e;
        string      t;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = name_q.pop_front();
                act = {bus.dmem_req_o, bus.pc_write_o, bus.ifid_write_o,
                       bus.ifid_flush_o, bus.idex_hold_o, bus.idex_bubble_o,
                       bus.exmem_hold_o, bus.memwb_bubble_o, bus.mem_timeout_o};
                n_cmp++;
                if (act !== e.ctl) begin
                    n_bad++;
                    $display("FAIL %s: ctl got %b want %b (req,pcw,ifw,fl,hold,bub,exh,mwb,tmo)",
                             t, act, e.ctl);
                end
`ifdef PIPE_PERF_CNT_EN
                n_cmp++;
                if (bus.stall_cnt_o !== e.scnt) begin
                    n_bad++;
                    $display("FAIL %s: stall_cnt got %0d want %0d",
                             t, bus.stall_cnt_o, e.scnt);
                end
`endif
            end
        end
    end

    initial begin : driver
        int dead_run;
        bus.IDEX_MemRead_i   = 0;
        bus.IDEX_rt_i        = 0;
        bus.IFID_rs_i        = 0;
        bus.IFID_rt_i        = 0;
        bus.branch_taken_i   = 0;
        bus.EXMEM_MemRead_i  = 0;
        bus.EXMEM_MemWrite_i = 0;
        bus.dmem_ack_i       = 0;

        step("rst0",     1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_req",  1, 1, 8, 8, 0, 1, 1, 0, 0);
        step("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("zw_store", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("ld_w0",    0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("ld_w1",    0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("ld_w2",    0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("ld_ack",   0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("ld_done",  0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_rs",    0, 1, 8, 8, 0, 0, 0, 0, 0);
        step("lu_clear", 0, 0, 8, 8, 0, 0, 0, 0, 0);
        step("lu_rt",    0, 1, 9, 1, 9, 0, 0, 0, 0);
        step("lu_zero",  0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("branch",   0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("lu_br",    0, 1, 8, 0, 8, 1, 0, 0, 0);
        step("ms_lu",    0, 1, 8, 8, 0, 1, 1, 0, 0);
        step("ms_ack",   0, 1, 8, 8, 0, 0, 1, 0, 1);
        step("ack_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step($sformatf("tmo%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        end
        step("err_ack",  0, 0, 0, 0, 0, 1, 1, 0, 1);
        step("err_idle", 0, 1, 8, 8, 0, 1, 0, 0, 0);
        step("rst_err",  1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mw_0",     0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mw_1",     0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("rst_mid",  1, 0, 0, 0, 0, 0, 1, 0, 0);
        step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        dead_run = 0;
        for (int i = 0; i < 2000; i++) begin
            bit r;
            dead_run = m_dead ? dead_run + 1 : 0;
            r = ($urandom_range(0, 99) < 2) || (dead_run > 4);
            step($sformatf("rnd%0d", i), r,
                 $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 9) < 4);
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
